// File: rtl/counter_pkg.sv
// Shared types and constants for the 0..9 step counter and its command driver.
package counter_pkg;

  localparam int CNT_TOP      = 9;
  localparam int CNT_STEP_BIG = 3;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    ISSUE,
    WAIT
  } cdrv_state_t;

endpackage

// File: rtl/counter_step_plan.sv
// Combinational planner: given the observed count and the target, picks the
// direction and step size of the next command, or reports that the target is met.
module counter_step_plan
  import counter_pkg::*;
(
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_hit,
  output logic             o_mode,
  output logic             o_step
);

  localparam logic [CNT_W:0] STEP_BIG = (CNT_W+1)'(CNT_STEP_BIG);

  logic [CNT_W:0] w_up_diff;
  logic [CNT_W:0] w_dn_diff;

  // Only the difference for the chosen direction is used, so the other wrapping is harmless.
  assign w_up_diff = {1'b0, i_target} - {1'b0, i_cnt};
  assign w_dn_diff = {1'b0, i_cnt} - {1'b0, i_target};

  assign o_hit  = (i_cnt == i_target);
  assign o_mode = (i_target > i_cnt);
  assign o_step = o_mode ? (w_up_diff >= STEP_BIG) : (w_dn_diff >= STEP_BIG);

endmodule

// File: rtl/counter_driver.sv
// Closed-loop command source for the 0..9 counter: accepts a target, issues one
// Mode/En/Step or Rst command at a time, re-reads Cnt after settling, reports Done/Err.
module counter_driver
  import counter_pkg::*;
#(
  parameter int TOP      = CNT_TOP,
  parameter int SETTLE   = 2,
  parameter int MAX_CMDS = 12
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [CNT_W-1:0] ReqTarget,
  input  logic             ReqClear,
  input  logic [CNT_W-1:0] Cnt,
  output logic             CntMode,
  output logic             CntEn,
  output logic             CntStep,
  output logic             CntRst,
  output logic             Done,
  output logic             Err,
  output logic [3:0]       Cmds
);

  localparam logic [CNT_W-1:0] TOP_L       = CNT_W'(TOP);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]       MAX_CMDS_L  = 4'(MAX_CMDS);

  cdrv_state_t      r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_target,   w_target_nxt;
  logic             r_clear,    w_clear_nxt;
  logic [3:0]       r_cmd_cnt,  w_cmd_cnt_nxt;
  logic [3:0]       r_timer,    w_timer_nxt;
  logic [CNT_W-1:0] r_prev_cnt, w_prev_cnt_nxt;
  logic             r_prev_vld, w_prev_vld_nxt;
  logic             r_ready,    w_ready_nxt;
  logic             r_mode,     w_mode_nxt;
  logic             r_step,     w_step_nxt;
  logic             r_en,       w_en_nxt;
  logic             r_cnt_rst,  w_cnt_rst_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_err,      w_err_nxt;
  logic [3:0]       r_cmds,     w_cmds_nxt;

  logic w_hit, w_mode, w_step;

  counter_step_plan u_plan (
    .i_cnt    (Cnt),
    .i_target (r_target),
    .o_hit    (w_hit),
    .o_mode   (w_mode),
    .o_step   (w_step)
  );

  always_comb begin
    // NOTE: every signal gets its default before the case so no latch is inferred.
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_clear_nxt    = r_clear;
    w_cmd_cnt_nxt  = r_cmd_cnt;
    w_timer_nxt    = r_timer;
    w_prev_cnt_nxt = r_prev_cnt;
    w_prev_vld_nxt = r_prev_vld;
    w_mode_nxt     = r_mode;
    w_step_nxt     = r_step;
    w_en_nxt       = 1'b0;
    w_cnt_rst_nxt  = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_cmds_nxt     = r_cmds;

    case (r_state)
      IDLE: begin
        if (ReqValid && r_ready) begin
          w_cmd_cnt_nxt  = '0;
          w_prev_vld_nxt = 1'b0;
          w_clear_nxt    = ReqClear;
          w_target_nxt   = ReqClear ? '0 : ReqTarget;
          if (ReqClear) begin
            w_cnt_rst_nxt = 1'b1;
            w_state_nxt   = ISSUE;
          end else if (ReqTarget > TOP_L) begin
            w_err_nxt  = 1'b1;
            w_cmds_nxt = '0;
          end else begin
            w_state_nxt = EVAL;
          end
        end
      end

      EVAL: begin
        if (w_hit) begin
          w_done_nxt  = 1'b1;
          w_cmds_nxt  = r_cmd_cnt;
          w_state_nxt = IDLE;
        end else if (r_clear || (r_prev_vld && Cnt == r_prev_cnt) ||
                     r_cmd_cnt == MAX_CMDS_L) begin
          // A clear gets exactly one command; a move that did not change Cnt is a stall.
          w_err_nxt   = 1'b1;
          w_cmds_nxt  = r_cmd_cnt;
          w_state_nxt = IDLE;
        end else begin
          w_mode_nxt     = w_mode;
          w_step_nxt     = w_step;
          w_en_nxt       = 1'b1;
          w_prev_cnt_nxt = Cnt;
          w_prev_vld_nxt = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end

      ISSUE: begin
        w_cmd_cnt_nxt = r_cmd_cnt + 4'd1;
        w_timer_nxt   = SETTLE_LAST;
        w_state_nxt   = WAIT;
      end

      WAIT: begin
        if (r_timer == '0) w_state_nxt = EVAL;
        else               w_timer_nxt = r_timer - 4'd1;
      end

      default: w_state_nxt = IDLE;
    endcase

    w_ready_nxt = (w_state_nxt == IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_clear    <= 1'b0;
      r_cmd_cnt  <= '0;
      r_timer    <= '0;
      r_prev_cnt <= '0;
      r_prev_vld <= 1'b0;
      r_ready    <= 1'b0;
      r_mode     <= 1'b0;
      r_step     <= 1'b0;
      r_en       <= 1'b0;
      // Counter is held clear for as long as Rst_n is low.
      r_cnt_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cmds     <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_clear    <= w_clear_nxt;
      r_cmd_cnt  <= w_cmd_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_prev_cnt <= w_prev_cnt_nxt;
      r_prev_vld <= w_prev_vld_nxt;
      r_ready    <= w_ready_nxt;
      r_mode     <= w_mode_nxt;
      r_step     <= w_step_nxt;
      r_en       <= w_en_nxt;
      r_cnt_rst  <= w_cnt_rst_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_cmds     <= w_cmds_nxt;
    end
  end

  assign ReqReady = r_ready;
  assign CntMode  = r_mode;
  assign CntEn    = r_en;
  assign CntStep  = r_step;
  assign CntRst   = r_cnt_rst;
  assign Done     = r_done;
  assign Err      = r_err;
  assign Cmds     = r_cmds;

endmodule

// File: tb/tb_counter_driver.sv
// Bench for counter_driver: pairs it with a behavioural 0..9 saturating counter and
// scores each request's outcome, command count, final Cnt and latency.
module tb_counter_driver;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic       ReqValid = 1'b0;
  logic [3:0] ReqTarget = 4'd0;
  logic       ReqClear = 1'b0;
  logic       ReqReady, CntMode, CntEn, CntStep, CntRst, Done, Err;
  logic [3:0] Cmds;

  logic [3:0] r_cnt_model = 4'd0;
  logic       stuck = 1'b0;
  logic [3:0] w_cnt_obs;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit is_err;
    int cmds;
    bit chk_cmds_port;
    int cnt;
    int lat;
    bit clr;
  } exp_t;

  exp_t sb[$];

  assign w_cnt_obs = stuck ? 4'd4 : r_cnt_model;

  always #5 Clk = ~Clk;

  counter_driver dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqTarget (ReqTarget),
    .ReqClear  (ReqClear),
    .Cnt       (w_cnt_obs),
    .CntMode   (CntMode),
    .CntEn     (CntEn),
    .CntStep   (CntStep),
    .CntRst    (CntRst),
    .Done      (Done),
    .Err       (Err),
    .Cmds      (Cmds)
  );

  function automatic logic [3:0] next_cnt(input logic [3:0] c, input logic up, input logic big);
    int s;
    int v;
    s = big ? 3 : 1;
    v = up ? int'(c) + s : int'(c) - s;
    if (v > 9) v = 9;
    if (v < 0) v = 0;
    return 4'(v);
  endfunction

  // Reference counter: updates on the falling edge, saturating at 0 and 9.
  always @(negedge Clk) begin
    if (CntRst)     r_cnt_model <= 4'd0;
    else if (CntEn) r_cnt_model <= next_cnt(r_cnt_model, CntMode, CntStep);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic request(input string tag, input logic [3:0] tgt, input logic clr,
                         input bit exp_err, input int exp_cmds, input bit chk_cmds_port,
                         input int exp_cnt, input int exp_lat);
    exp_t e;
    int   w;
    int   lat;
    int   en_pulses;
    int   rst_pulses;
    int   busy_ready;
    int   both;
    bit   got;

    e.is_err = exp_err;
    e.cmds = exp_cmds;
    e.chk_cmds_port = chk_cmds_port;
    e.cnt = exp_cnt;
    e.lat = exp_lat;
    e.clr = clr;
    sb.push_back(e);

    @(negedge Clk);
    ReqTarget = tgt;
    ReqClear  = clr;
    ReqValid  = 1'b1;
    w = 0;
    while (!ReqReady && w < 50) begin
      @(negedge Clk);
      w++;
    end
    check({tag, "_ready"}, int'(ReqReady), 1);
    if (!ReqReady) begin
      ReqValid = 1'b0;
      void'(sb.pop_front());
      return;
    end

    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    lat = 0; en_pulses = 0; rst_pulses = 0; busy_ready = 0; both = 0; got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (c > 0) begin
        @(posedge Clk);
        #1;
      end
      if (Done && Err) both++;
      if (CntEn) en_pulses++;
      if (CntRst) rst_pulses++;
      if (Done || Err) begin
        got = 1'b1;
        lat = c;
      end else if (ReqReady) begin
        busy_ready++;
      end
    end

    e = sb.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_done"}, int'(Done), e.is_err ? 0 : 1);
    check({tag, "_err"}, int'(Err), e.is_err ? 1 : 0);
    check({tag, "_both"}, both, 0);
    check({tag, "_busy_ready"}, busy_ready, 0);
    if (e.chk_cmds_port) check({tag, "_cmds_port"}, int'(Cmds), e.cmds);
    check({tag, "_issued"}, en_pulses + rst_pulses, e.cmds);
    check({tag, "_rst_pulses"}, rst_pulses, e.clr ? 1 : 0);
    check({tag, "_cnt"}, int'(w_cnt_obs), e.cnt);
    check({tag, "_latency"}, lat, e.lat);

    @(posedge Clk);
    #1;
    check({tag, "_pulse_end"}, int'(Done) + int'(Err), 0);
  endtask

  initial begin
    int en_seen;
    int flags;
    int w;

    #1 Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_cntrst", int'(CntRst), 1);
    check("rst_ready", int'(ReqReady), 0);
    check("rst_outs", int'(Done) + int'(Err) + int'(CntEn) + int'(CntMode) + int'(CntStep), 0);
    check("rst_cmds", int'(Cmds), 0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check("rel_cntrst", int'(CntRst), 0);
    check("rel_ready", int'(ReqReady), 1);
    check("rel_cnt", int'(r_cnt_model), 0);

    //        tag        tgt  clr  err  cmds port cnt lat
    request("t1_up7",   4'd7,  0,   0,   3,   1,   7,  13);
    request("t2_dn1",   4'd1,  0,   0,   2,   1,   1,   9);
    request("t3_ill",   4'd12, 0,   1,   0,   0,   1,   0);
    request("t4_to5",   4'd5,  0,   0,   2,   1,   5,   9);
    request("t4_clr",   4'd9,  1,   0,   1,   1,   0,   4);
    stuck = 1'b1;
    request("t5_stall", 4'd8,  0,   1,   1,   1,   4,   5);
    stuck = 1'b0;
    check("t5_model_cnt", int'(r_cnt_model), 3);
    request("clr2",     4'd0,  1,   0,   1,   1,   0,   4);
    request("hit0",     4'd0,  0,   0,   0,   1,   0,   1);
    request("up9",      4'd9,  0,   0,   3,   1,   9,  13);
    request("dn0",      4'd0,  0,   0,   3,   1,   0,  13);

    // Abort: reset mid-request after the second command pulse.
    @(negedge Clk);
    ReqTarget = 4'd9;
    ReqClear  = 1'b0;
    ReqValid  = 1'b1;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    en_seen = 0;
    flags = 0;
    w = 0;
    while (en_seen < 2 && w < 100) begin
      @(posedge Clk);
      #1;
      w++;
      if (CntEn) en_seen++;
      flags += int'(Done) + int'(Err);
    end
    check("t6_two_en", en_seen, 2);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("t6_rst_cntrst", int'(CntRst), 1);
    check("t6_rst_ready", int'(ReqReady), 0);
    flags += int'(Done) + int'(Err);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) begin
      @(posedge Clk);
      #1;
      flags += int'(Done) + int'(Err);
    end
    check("t6_no_done_err", flags, 0);
    check("t6_ready", int'(ReqReady), 1);
    check("t6_cntrst_low", int'(CntRst), 0);
    check("t6_cmds", int'(Cmds), 0);
    check("t6_cnt_cleared", int'(r_cnt_model), 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
